fir_axi_param: RTL and testbench

- Next-generation FIR engine: runtime-selectable tap count up to pTAP_MAX, signed coefficients, internal circular sample buffer, sequential one-tap-per-cycle MAC.
- Configured and controlled over AXI-Lite (ap_ctrl, length, tap count, output mode, coefficients).
- Streams X[n] in and Y[n] out over AXI-Stream with full sm_tready backpressure and optional arithmetic shift and saturation on the output.
- Sits between the DMA stream ports and the host register bus.

---
 rtl/fir_axi_pkg.sv | 32 +++
 rtl/fir_axi_param_regs.sv | 175 +++++++++++++++++
 rtl/fir_axi_param.sv | 195 +++++++++++++++++++
 tb/tb_fir_axi_param.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_axi_pkg.sv
// Shared definitions for the AXI FIR engine:
// register map, ap_ctrl bits and FSM encodings.
package fir_axi_pkg;

  localparam int unsigned ADDR_AP_CTRL   = 'h00;
  localparam int unsigned ADDR_LEN       = 'h10;
  localparam int unsigned ADDR_TAPNUM    = 'h14;
  localparam int unsigned ADDR_CFG       = 'h18;
  localparam int unsigned ADDR_COEF_BASE = 'h80;

  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;
  localparam int AP_TLERR = 3;
  localparam int CFG_SAT  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_MAC,
    S_OUT
  } strm_state_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_WR,
    A_RA,
    A_RD
  } axil_state_e;

endpackage

// File: rtl/fir_axi_param_regs.sv
// AXI-Lite slave: register file, tap clamp,
// coefficient storage and done clear-on-read.
module fir_axil_regs
  import fir_axi_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_MAX    = 32,
  parameter int pLEN_WIDTH  = 16,
  localparam int TNW = $clog2(pTAP_MAX + 1),
  localparam int IW  = $clog2(pTAP_MAX)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   idle_i,
  input  logic                   done_set_i,
  input  logic                   tlerr_set_i,
  output logic                   start_o,
  output logic [pLEN_WIDTH-1:0]  len_o,
  output logic [TNW-1:0]         tap_num_o,
  output logic [5:0]             shift_o,
  output logic                   sat_o,
  input  logic [IW-1:0]          coef_idx_i,
  output logic [pDATA_WIDTH-1:0] coef_o
);

  localparam int AW = pADDR_WIDTH;
  localparam int DW = pDATA_WIDTH;

  axil_state_e st_q, st_d;

  logic [pLEN_WIDTH-1:0] len_q;
  logic [TNW-1:0]        tap_q, tap_w;
  logic [5:0]            shift_q;
  logic                  sat_q, done_q, tlerr_q;
  logic                  rd_ctrl_q;
  logic [DW-1:0]         rdata_q, rd_mux;
  logic [DW-1:0]         coef_q [pTAP_MAX];

  logic          we, cfg_we, re_beat;
  logic [AW-1:0] woff, roff;
  logic          whit, rhit;

  always_ff @(posedge clk_i) begin
    if (rst_i) st_q <= A_IDLE;
    else       st_q <= st_d;
  end

  // Write wins over a read presented in the same cycle
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      A_IDLE: begin
        if (awvalid && wvalid) st_d = A_WR;
        else if (arvalid)      st_d = A_RA;
      end
      A_WR:    st_d = A_IDLE;
      A_RA:    st_d = A_RD;
      A_RD:    if (rready) st_d = A_IDLE;
      default: st_d = A_IDLE;
    endcase
  end

  assign awready = (st_q == A_WR);
  assign wready  = (st_q == A_WR);
  assign arready = (st_q == A_RA);
  assign rvalid  = (st_q == A_RD);
  assign rdata   = rdata_q;

  assign we      = (st_q == A_WR);
  assign cfg_we  = we && idle_i;
  assign re_beat = rvalid && rready;

  assign woff = awaddr - AW'(ADDR_COEF_BASE);
  assign roff = araddr - AW'(ADDR_COEF_BASE);
  assign whit = (awaddr >= AW'(ADDR_COEF_BASE))
             && (woff[1:0] == 2'b00)
             && ((woff >> 2) < AW'(pTAP_MAX));
  assign rhit = (araddr >= AW'(ADDR_COEF_BASE))
             && (roff[1:0] == 2'b00)
             && ((roff >> 2) < AW'(pTAP_MAX));

  assign start_o = we && idle_i && wdata[AP_START]
                && (awaddr == AW'(ADDR_AP_CTRL));

  always_comb begin
    if (wdata == '0)
      tap_w = TNW'(1);
    else if (wdata > DW'(pTAP_MAX))
      tap_w = TNW'(pTAP_MAX);
    else
      tap_w = wdata[TNW-1:0];
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (araddr == AW'(ADDR_AP_CTRL)): begin
        rd_mux[AP_DONE]  = done_q;
        rd_mux[AP_IDLE]  = idle_i;
        rd_mux[AP_TLERR] = tlerr_q;
      end
      (araddr == AW'(ADDR_LEN)):
        rd_mux[pLEN_WIDTH-1:0] = len_q;
      (araddr == AW'(ADDR_TAPNUM)):
        rd_mux[TNW-1:0] = tap_q;
      (araddr == AW'(ADDR_CFG)): begin
        rd_mux[5:0]     = shift_q;
        rd_mux[CFG_SAT] = sat_q;
      end
      rhit:
        rd_mux = coef_q[roff[IW+1:2]];
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q     <= '0;
      tap_q     <= TNW'(pTAP_MAX);
      shift_q   <= '0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
      tlerr_q   <= 1'b0;
      rd_ctrl_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (cfg_we && awaddr == AW'(ADDR_LEN))
        len_q <= wdata[pLEN_WIDTH-1:0];
      if (cfg_we && awaddr == AW'(ADDR_TAPNUM))
        tap_q <= tap_w;
      if (cfg_we && awaddr == AW'(ADDR_CFG)) begin
        shift_q <= wdata[5:0];
        sat_q   <= wdata[CFG_SAT];
      end
      if (done_set_i)
        done_q <= 1'b1;
      else if (re_beat && rd_ctrl_q)
        done_q <= 1'b0;
      if (start_o)
        tlerr_q <= 1'b0;
      else if (tlerr_set_i)
        tlerr_q <= 1'b1;
      if (st_q == A_RA) begin
        rdata_q   <= rd_mux;
        rd_ctrl_q <= (araddr == AW'(ADDR_AP_CTRL));
      end
    end
  end

  // Coefficients survive reset
  always_ff @(posedge clk_i) begin
    if (cfg_we && whit)
      coef_q[woff[IW+1:2]] <= wdata;
  end

  assign coef_o    = coef_q[coef_idx_i];
  assign len_o     = len_q;
  assign tap_num_o = tap_q;
  assign shift_o   = shift_q;
  assign sat_o     = sat_q;

endmodule

// File: rtl/fir_axi_param.sv
// FIR engine top: sample ring buffer, serial MAC
// datapath and stream FSM behind an AXI-Lite front.
module fir_axi_param
  import fir_axi_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_MAX    = 32,
  parameter int pLEN_WIDTH  = 16
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam int DW   = pDATA_WIDTH;
  localparam int LW   = pLEN_WIDTH;
  localparam int TNW  = $clog2(pTAP_MAX + 1);
  localparam int IW   = $clog2(pTAP_MAX);
  localparam int ACCW = 2 * DW + $clog2(pTAP_MAX);

  logic           start, idle, done_set, tlerr_set;
  logic [LW-1:0]  len;
  logic [TNW-1:0] tap;
  logic [5:0]     shift;
  logic           sat;
  logic [DW-1:0]  coef;

  strm_state_e st_q, st_d;

  logic [IW-1:0]          clr_q, wr_q, rd_q;
  logic [TNW-1:0]         k_q;
  logic signed [ACCW-1:0] acc_q, sh;
  logic [LW-1:0]          in_q, out_q, in_nx, out_nx;
  logic [DW-1:0]          y_q, y_d;
  logic                   last_q;
  logic signed [DW-1:0]   smp_q [pTAP_MAX];
  logic signed [2*DW-1:0] prod;
  logic                   in_hs, out_hs, fits;

  fir_axil_regs #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH),
    .pTAP_MAX    (pTAP_MAX),
    .pLEN_WIDTH  (pLEN_WIDTH)
  ) u_regs (
    .clk_i       (axis_clk),
    .rst_i       (axis_rst),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .idle_i      (idle),
    .done_set_i  (done_set),
    .tlerr_set_i (tlerr_set),
    .start_o     (start),
    .len_o       (len),
    .tap_num_o   (tap),
    .shift_o     (shift),
    .sat_o       (sat),
    .coef_idx_i  (k_q[IW-1:0]),
    .coef_o      (coef)
  );

  assign idle      = (st_q == S_IDLE);
  assign ss_tready = (st_q == S_LOAD);
  assign sm_tvalid = (st_q == S_OUT);
  assign sm_tdata  = y_q;
  assign sm_tlast  = sm_tvalid && last_q;

  assign in_hs  = ss_tvalid && ss_tready;
  assign out_hs = sm_tvalid && sm_tready;
  assign in_nx  = in_q + LW'(1);
  assign out_nx = out_q + LW'(1);

  assign done_set  = (idle && start && len == '0)
                  || (out_hs && out_nx == len);
  assign tlerr_set = in_hs && (ss_tlast != (in_nx == len));

  assign prod = $signed(coef) * smp_q[rd_q];
  assign sh   = acc_q >>> shift;
  assign fits = (&sh[ACCW-1:DW-1]) || ~(|sh[ACCW-1:DW-1]);

  always_comb begin
    y_d = sh[DW-1:0];
    if (sat && !fits)
      y_d = sh[ACCW-1] ? {1'b1, {(DW-1){1'b0}}}
                       : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) st_q <= S_IDLE;
    else          st_q <= st_d;
  end

  // MAC runs one extra cycle to register the formatted result
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:  if (start && len != '0) st_d = S_CLEAR;
      S_CLEAR: if (clr_q == IW'(pTAP_MAX - 1)) st_d = S_LOAD;
      S_LOAD:  if (ss_tvalid) st_d = S_MAC;
      S_MAC:   if (k_q == tap) st_d = S_OUT;
      S_OUT: begin
        if (sm_tready)
          st_d = (out_nx == len) ? S_IDLE : S_LOAD;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      clr_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      in_q   <= '0;
      out_q  <= '0;
      y_q    <= '0;
      last_q <= 1'b0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (start) begin
            clr_q <= '0;
            wr_q  <= '0;
            in_q  <= '0;
            out_q <= '0;
          end
        end
        S_CLEAR: clr_q <= clr_q + IW'(1);
        S_LOAD: begin
          if (ss_tvalid) begin
            rd_q  <= wr_q;
            wr_q  <= (TNW'(wr_q) == tap - TNW'(1))
                   ? '0 : wr_q + IW'(1);
            k_q   <= '0;
            acc_q <= '0;
            in_q  <= in_nx;
          end
        end
        S_MAC: begin
          if (k_q != tap) begin
            acc_q <= acc_q + ACCW'(prod);
            rd_q  <= (rd_q == '0)
                   ? IW'(tap - TNW'(1)) : rd_q - IW'(1);
            k_q   <= k_q + TNW'(1);
          end else begin
            y_q    <= y_d;
            last_q <= (out_nx == len);
          end
        end
        S_OUT: if (sm_tready) out_q <= out_nx;
        default: ;
      endcase
    end
  end

  always_ff @(posedge axis_clk) begin
    if (st_q == S_CLEAR)
      smp_q[clr_q] <= '0;
    else if (in_hs)
      smp_q[wr_q] <= ss_tdata;
  end

endmodule

// File: tb/tb_fir_axi_param.sv
// Directed bench for fir_axi_param: impulse, backpressure,
// saturation, config guard, rerun/tlast and reset abort.
module tb_fir_axi_param;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        awvalid = 0, wvalid = 0, arvalid = 0, rready = 0;
  logic        awready, wready, arready, rvalid;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic        ss_tvalid = 0, ss_tlast = 0, ss_tready;
  logic [31:0] ss_tdata = '0;
  logic        sm_tvalid, sm_tlast;
  logic        sm_tready = 0;
  logic [31:0] sm_tdata;

  fir_axi_param #(
    .pADDR_WIDTH (12),
    .pDATA_WIDTH (32),
    .pTAP_MAX    (32),
    .pLEN_WIDTH  (16)
  ) dut (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .ss_tvalid (ss_tvalid),
    .ss_tready (ss_tready),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .sm_tvalid (sm_tvalid),
    .sm_tready (sm_tready),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast)
  );

  always #5 axis_clk = ~axis_clk;

  int cyc = 0;
  always @(posedge axis_clk) cyc++;

  int total = 0, bad = 0;
  int hold_bad = 0, ovl_bad = 0;
  int t_acc = 0, t_out = 0;
  int xin [64];
  bit tl [64];
  logic [31:0] got [64];
  bit lastm [64];
  logic [31:0] rd;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic axil_wr(input logic [11:0] a,
                         input logic [31:0] d);
    int w;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1; w = 0;
    @(negedge axis_clk);
    while (!awready && w < 50) begin
      @(negedge axis_clk); w++;
    end
    if (!awready) chk("aw_timeout", 0, 1);
    @(posedge axis_clk); #1;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic axil_rd(input logic [11:0] a,
                         output logic [31:0] d);
    int w;
    araddr = a; arvalid = 1; w = 0;
    @(negedge axis_clk);
    while (!arready && w < 50) begin
      @(negedge axis_clk); w++;
    end
    if (!arready) chk("ar_timeout", 0, 1);
    @(posedge axis_clk); #1;
    arvalid = 0; rready = 1; w = 0;
    @(negedge axis_clk);
    while (!rvalid && w < 50) begin
      @(negedge axis_clk); w++;
    end
    if (!rvalid) chk("r_timeout", 0, 1);
    d = rdata;
    @(posedge axis_clk); #1;
    rready = 0;
  endtask

  task automatic send(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      ss_tvalid = 1; ss_tdata = xin[i]; ss_tlast = tl[i]; w = 0;
      @(negedge axis_clk);
      while (!ss_tready && w < 400) begin
        @(negedge axis_clk); w++;
      end
      if (!ss_tready) begin
        chk("ss_timeout", 0, 1);
        break;
      end
      if (i == 0) t_acc = cyc + 1;
      @(posedge axis_clk); #1;
    end
    ss_tvalid = 0; ss_tlast = 0;
  endtask

  task automatic recv(input int n, input bit bp);
    int k, w;
    bit pv, first;
    logic [31:0] pd;
    k = 0; w = 0; pv = 0; first = 1; pd = '0;
    while (k < n && w < 3000) begin
      @(negedge axis_clk); w++;
      if (pv && (!sm_tvalid || sm_tdata !== pd)) hold_bad++;
      if (sm_tvalid && ss_tready) ovl_bad++;
      sm_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sm_tvalid && first) begin
        t_out = cyc; first = 0;
      end
      if (sm_tvalid && sm_tready) begin
        got[k] = sm_tdata; lastm[k] = sm_tlast; k++; pv = 0;
      end else begin
        pv = sm_tvalid; pd = sm_tdata;
      end
    end
    if (k < n) chk("sm_timeout", k, n);
    @(posedge axis_clk); #1;
    sm_tready = 0;
  endtask

  task automatic run(input int n, input bit bp);
    fork
      send(n);
      recv(n, bp);
    join
  endtask

  function automatic int tmask(input int n);
    int m = 0;
    for (int i = 0; i < n; i++) m |= int'(lastm[i]) << i;
    return m;
  endfunction

  task automatic clr_in;
    for (int i = 0; i < 64; i++) begin
      xin[i] = 0; tl[i] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int e [16];
    int s, cnt;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("rst_ctl", {awready, wready, arready, rvalid,
                    ss_tready, sm_tvalid, sm_tlast}, 0);
    chk("rst_data", {rdata, sm_tdata}, 0);
    axis_rst = 0;
    axil_rd(12'h00, rd); chk("rst_ap", rd, 32'h4);
    axil_rd(12'h14, rd); chk("rst_tap", rd, 32);
    axil_rd(12'h10, rd); chk("rst_len", rd, 0);
    axil_rd(12'h18, rd); chk("rst_cfg", rd, 0);

    // impulse
    axil_wr(12'h14, 4);
    for (int i = 0; i < 4; i++) axil_wr(12'(12'h80 + 4 * i), i + 1);
    axil_wr(12'h10, 6);
    axil_wr(12'h18, 0);
    clr_in(); xin[0] = 1; tl[5] = 1;
    axil_wr(12'h00, 1);
    run(6, 0);
    e[0] = 1; e[1] = 2; e[2] = 3; e[3] = 4; e[4] = 0; e[5] = 0;
    for (int i = 0; i < 6; i++) chk($sformatf("imp_y%0d", i), got[i], e[i]);
    chk("imp_tlast", tmask(6), 32);
    chk("imp_lat", t_out - t_acc, 5);
    axil_rd(12'h00, rd); chk("imp_done", rd, 32'h6);
    axil_rd(12'h00, rd); chk("imp_rdclr", rd, 32'h4);

    // backpressure
    axil_wr(12'h14, 11);
    for (int i = 0; i < 11; i++) axil_wr(12'(12'h80 + 4 * i), i + 1);
    axil_wr(12'h10, 16);
    clr_in();
    for (int i = 0; i < 16; i++) xin[i] = i + 1;
    tl[15] = 1;
    hold_bad = 0; ovl_bad = 0;
    axil_wr(12'h00, 1);
    run(16, 1);
    for (int n = 0; n < 16; n++) begin
      s = 0;
      for (int k = 0; k < 11; k++)
        if (n - k >= 0) s += (k + 1) * (n - k + 1);
      chk($sformatf("bp_y%0d", n), got[n], s);
    end
    chk("bp_hold", hold_bad, 0);
    chk("bp_ovl", ovl_bad, 0);
    chk("bp_tlast", tmask(16), 1 << 15);

    // saturation then truncation
    axil_wr(12'h14, 2);
    axil_wr(12'h80, 32'h7FFFFFFF);
    axil_wr(12'h84, 32'h7FFFFFFF);
    axil_wr(12'h10, 3);
    axil_wr(12'h18, 32'h100);
    axil_rd(12'h18, rd); chk("cfg_rd", rd, 32'h100);
    clr_in();
    for (int i = 0; i < 3; i++) xin[i] = 32'h7FFFFFFF;
    tl[2] = 1;
    axil_wr(12'h00, 1);
    run(3, 0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("sat_y%0d", i), got[i], 32'h7FFFFFFF);
    axil_wr(12'h18, 31);
    axil_wr(12'h00, 1);
    run(3, 0);
    chk("trc_y0", got[0], 32'h7FFFFFFE);
    chk("trc_y1", got[1], 32'hFFFFFFFC);
    chk("trc_y2", got[2], 32'hFFFFFFFC);

    // clamp and zero-length run
    axil_wr(12'h14, 0);
    axil_rd(12'h14, rd); chk("tap_lo", rd, 1);
    axil_wr(12'h14, 100);
    axil_rd(12'h14, rd); chk("tap_hi", rd, 32);
    axil_rd(12'h00, rd);
    axil_wr(12'h10, 0);
    axil_wr(12'h00, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge axis_clk);
      if (sm_tvalid || ss_tready) cnt++;
    end
    chk("len0_quiet", cnt, 0);
    axil_rd(12'h00, rd); chk("len0_done", rd, 32'h6);

    // rerun, coef guard, tlast error
    axil_wr(12'h14, 3);
    axil_wr(12'h80, 2);
    axil_wr(12'h84, 3);
    axil_wr(12'h88, 5);
    axil_wr(12'h10, 5);
    axil_wr(12'h18, 0);
    clr_in();
    for (int i = 0; i < 5; i++) xin[i] = i + 1;
    tl[4] = 1;
    axil_wr(12'h00, 1);
    axil_wr(12'h80, 32'h55);
    axil_rd(12'h80, rd); chk("coef_guard", rd, 2);
    run(5, 0);
    e[0] = 2; e[1] = 7; e[2] = 17; e[3] = 27; e[4] = 37;
    for (int i = 0; i < 5; i++) chk($sformatf("r1_y%0d", i), got[i], e[i]);
    axil_rd(12'h00, rd); chk("r1_ap", rd, 32'h6);
    clr_in();
    xin[0] = 7;
    for (int i = 1; i < 5; i++) xin[i] = 1;
    tl[2] = 1;
    axil_wr(12'h00, 1);
    run(5, 0);
    e[0] = 14; e[1] = 23; e[2] = 40; e[3] = 10; e[4] = 10;
    for (int i = 0; i < 5; i++) chk($sformatf("r2_y%0d", i), got[i], e[i]);
    axil_rd(12'h00, rd); chk("r2_tlerr", rd, 32'hE);

    // reset during MAC
    axil_wr(12'h14, 32);
    axil_wr(12'h10, 2);
    clr_in(); xin[0] = 3;
    axil_wr(12'h00, 1);
    send(1);
    repeat (5) @(posedge axis_clk);
    #1 axis_rst = 1;
    @(posedge axis_clk);
    #1 axis_rst = 0;
    @(negedge axis_clk);
    chk("abort_strm", {sm_tvalid, ss_tready, sm_tlast}, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge axis_clk);
      if (sm_tvalid) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    axil_rd(12'h00, rd); chk("abort_ap", rd, 32'h4);
    axil_rd(12'h10, rd); chk("abort_len", rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
